// File: rtl/conv_pkg.sv
// Shared definitions for the convolution tile scheduler: FSM states and the
// constant functions that derive output-map and tile geometry.
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } state_t;

  // Integer square root, rounded down; tiles-per-side from the tile count.
  function automatic int isqrt(input int n);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= n) r++;
    return r;
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Bit width that never collapses to zero for degenerate sizes.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Geometry of the default configuration (512x512 image, 3x3 kernel, 64 tiles).
  localparam int OUT  = 512 - 3 + 1;
  localparam int TPS  = isqrt(64);
  localparam int TILE = ceil_div(OUT, TPS);
  localparam int CW   = clog2_min1(512);
  localparam int TW   = clog2_min1(64);

endpackage

// File: rtl/tile_counter.sv
// Nested tile/pixel counters: walks tiles in raster order and pixels inside
// each tile in raster order, clipping the last tile row/column to the map edge.
module tile_counter
  import conv_pkg::*;
#(
  parameter int OUT  = 6,
  parameter int TILE = 3,
  parameter int TPS  = 2,
  parameter int CW   = 3,
  parameter int TW   = 2
) (
  input  logic          clock,
  input  logic          nreset,
  input  logic          clear,
  input  logic          advance,
  output logic [CW-1:0] row,
  output logic [CW-1:0] col,
  output logic [TW-1:0] tile_idx,
  output logic          last
);

  localparam int TRW = clog2_min1(TPS);

  logic [CW-1:0]  row_base, col_base;
  logic [TRW-1:0] tr, tc;
  int             row_end, col_end;
  logic           col_at_end, row_at_end, tc_last, tr_last;

  // Clipped tile bounds and end-of-tile / end-of-map flags.
  always_comb begin
    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    row_end    = ((int'(row_base) + TILE < OUT) ? int'(row_base) + TILE : OUT) - 1;
    col_end    = ((int'(col_base) + TILE < OUT) ? int'(col_base) + TILE : OUT) - 1;
    col_at_end = (int'(col) == col_end);
    row_at_end = (int'(row) == row_end);
    tc_last    = (int'(tc) == TPS - 1) || (int'(col_base) + TILE >= OUT);
    tr_last    = (int'(tr) == TPS - 1) || (int'(row_base) + TILE >= OUT);
    last       = col_at_end && row_at_end && tc_last && tr_last;
  end

  assign tile_idx = TW'(int'(tr) * TPS + int'(tc));

  // Step to the next pixel; roll over to the next tile column, then tile row.
  always_ff @(posedge clock or posedge nreset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (nreset) begin
      row <= '0; col <= '0; row_base <= '0; col_base <= '0; tr <= '0; tc <= '0;
    end else if (clear) begin
      row <= '0; col <= '0; row_base <= '0; col_base <= '0; tr <= '0; tc <= '0;
    end else if (advance) begin
      if (!col_at_end) begin
        col <= col + CW'(1);
      end else if (!row_at_end) begin
        row <= row + CW'(1);
        col <= col_base;
      end else if (!tc_last) begin
        tc       <= tc + TRW'(1);
        col_base <= col_base + CW'(TILE);
        col      <= col_base + CW'(TILE);
        row      <= row_base;
      end else if (!tr_last) begin
        tr       <= tr + TRW'(1);
        tc       <= '0;
        row_base <= row_base + CW'(TILE);
        row      <= row_base + CW'(TILE);
        col_base <= '0;
        col      <= '0;
      end else begin
        row <= '0; col <= '0; row_base <= '0; col_base <= '0; tr <= '0; tc <= '0;
      end
    end
  end

endmodule

// File: rtl/conv_tile_scheduler.sv
// Sequences one convolution window per output pixel, tile by tile, and
// forwards each engine result with its coordinate to the result store.
module conv_tile_scheduler
  import conv_pkg::*;
#(
  parameter int SIZE         = 512,
  parameter int SIZEKer      = 3,
  parameter int WIDTH_BIT    = 8,
  parameter int TOTSUBIMAGEM = 64
) (
  input  logic                               clock,
  input  logic                               nreset,
  input  logic                               start,
  input  logic                               abort,
  output logic                               busy,
  output logic                               done,
  output logic [$clog2(TOTSUBIMAGEM)-1:0]    tile_idx,
  output logic                               eng_start,
  input  logic                               eng_ready,
  output logic [$clog2(SIZE)-1:0]            eng_row,
  output logic [$clog2(SIZE)-1:0]            eng_col,
  input  logic                               eng_valid,
  input  logic signed [WIDTH_BIT-1:0]        eng_result,
  output logic                               wr_en,
  output logic [$clog2(SIZE)-1:0]            wr_row,
  output logic [$clog2(SIZE)-1:0]            wr_col,
  output logic signed [WIDTH_BIT-1:0]        wr_data
);

  localparam int OUT_S  = SIZE - SIZEKer + 1;
  localparam int TPS_S  = isqrt(TOTSUBIMAGEM);
  localparam int TILE_S = ceil_div(OUT_S, TPS_S);
  localparam int CW_S   = $clog2(SIZE);
  localparam int TW_S   = $clog2(TOTSUBIMAGEM);

  state_t state, state_nx;
  logic   clear, advance, last;

  tile_counter #(
    .OUT (OUT_S),
    .TILE(TILE_S),
    .TPS (TPS_S),
    .CW  (CW_S),
    .TW  (TW_S)
  ) u_tile_counter (
    .clock   (clock),
    .nreset  (nreset),
    .clear   (clear),
    .advance (advance),
    .row     (eng_row),
    .col     (eng_col),
    .tile_idx(tile_idx),
    .last    (last)
  );

  // State register.
  always_ff @(posedge clock or posedge nreset) begin
    if (nreset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next state and counter control; abort wins over start and eng_valid.
  always_comb begin
    state_nx = state;
    clear    = 1'b0;
    advance  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (abort) begin
          state_nx = ST_IDLE;
        end else if (start) begin
          state_nx = ST_ISSUE;
          clear    = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (abort)          state_nx = ST_IDLE;
        else if (eng_ready) state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (abort)          state_nx = ST_IDLE;
        else if (eng_valid) state_nx = ST_WRITE;
      end
      ST_WRITE: begin
        if (abort) begin
          state_nx = ST_IDLE;
        end else begin
          advance  = 1'b1;
          state_nx = last ? ST_DONE : ST_ISSUE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Capture the engine result with the coordinate it belongs to.
  always_ff @(posedge clock or posedge nreset) begin
    if (nreset) begin
      wr_row  <= '0;
      wr_col  <= '0;
      wr_data <= '0;
    end else if (state == ST_WAIT && eng_valid && !abort) begin
      wr_row  <= eng_row;
      wr_col  <= eng_col;
      wr_data <= eng_result;
    end
  end

  assign busy      = (state == ST_ISSUE) || (state == ST_WAIT) || (state == ST_WRITE);
  assign done      = (state == ST_DONE);
  assign eng_start = (state == ST_ISSUE);
  assign wr_en     = (state == ST_WRITE);

endmodule
